// File: rtl/cpu_plic_pkg.sv
// cpu_plic shared definitions.
// Register byte offsets and bus FSM states.
package cpu_plic_pkg;

  localparam logic [7:0] PLIC_PENDING       = 8'h00;
  localparam logic [7:0] PLIC_ENABLE        = 8'h04;
  localparam logic [7:0] PLIC_THRESHOLD     = 8'h08;
  localparam logic [7:0] PLIC_CLAIM         = 8'h0C;
  localparam logic [7:0] PLIC_PRIORITY_BASE = 8'h10;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

endpackage

// File: rtl/cpu_plic_gateway.sv
// cpu_plic per-source gateway.
// Synchronizer, pending latch and in-service mask.
module cpu_plic_gateway
  import cpu_plic_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic pend_q, pend_d;
  logic insv_q, insv_d;

  always_comb begin
    sync1_d = i_level;
    sync2_d = sync1_q;
    pend_d  = pend_q;
    insv_d  = insv_q;
    // claim wins over a same-cycle set
    if (i_claim) begin
      pend_d = 1'b0;
      insv_d = 1'b1;
    end else begin
      if (sync2_q && !insv_q) pend_d = 1'b1;
      if (i_complete) insv_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pend_q  <= 1'b0;
      insv_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pend_q  <= pend_d;
      insv_q  <= insv_d;
    end
  end

  assign o_pending    = pend_q;
  assign o_in_service = insv_q;

endmodule

// File: rtl/cpu_plic.sv
// cpu_plic: platform-level interrupt controller.
// Gateways, registered priority arbiter and claim/complete bus port.
module cpu_plic
  import cpu_plic_pkg::*;
#(
  parameter int SOURCES        = 8,
  parameter int PRIORITY_WIDTH = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [SOURCES-1:0] i_interrupt,
  output logic               o_interrupt,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [7:0]         i_address,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready
);

  localparam int ID_W = $clog2(SOURCES + 1);
  localparam int PW   = PRIORITY_WIDTH;

  logic [SOURCES-1:0] pending;
  logic [SOURCES-1:0] in_service;
  logic [SOURCES-1:0] claim_stb;
  logic [SOURCES-1:0] complete_stb;

  logic [SOURCES-1:0] enable_q, enable_d;
  logic [PW-1:0]      prio_q [SOURCES];
  logic [PW-1:0]      prio_d [SOURCES];
  logic [PW-1:0]      thresh_q, thresh_d;
  logic [ID_W-1:0]    best_id_q, best_id_d;
  logic               irq_q, irq_d;
  bus_state_e         state_q, state_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;

  logic [5:0]  word;
  logic [5:0]  prio_idx;
  logic        is_prio;
  logic        access;
  logic        wr;
  logic        rd;
  logic [PW-1:0] prio_rd;
  logic [31:0] rd_val;
  logic [PW-1:0] best_p;
  logic        unused_addr;

  assign word        = i_address[7:2];
  assign unused_addr = ^i_address[1:0];
  assign prio_idx    = word - PLIC_PRIORITY_BASE[7:2];
  assign is_prio     = (word >= PLIC_PRIORITY_BASE[7:2])
                    && (32'(prio_idx) < SOURCES);
  assign access      = (state_q == BUS_IDLE) && i_request;
  assign wr          = access && i_rw;
  assign rd          = access && !i_rw;

  for (genvar n = 0; n < SOURCES; n++) begin : g_src
    assign claim_stb[n] = rd
      && (word == PLIC_CLAIM[7:2])
      && (best_id_q == ID_W'(n + 1));
    assign complete_stb[n] = wr
      && (word == PLIC_CLAIM[7:2])
      && (i_wdata == 32'(n + 1))
      && in_service[n];

    cpu_plic_gateway u_gw (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_level      (i_interrupt[n]),
      .i_claim      (claim_stb[n]),
      .i_complete   (complete_stb[n]),
      .o_pending    (pending[n]),
      .o_in_service (in_service[n])
    );
  end

  // ascending scan with strict '>' keeps the lowest ID on ties
  always_comb begin
    best_id_d = '0;
    best_p    = thresh_q;
    for (int n = 0; n < SOURCES; n++) begin
      if (pending[n] && enable_q[n] && (prio_q[n] > best_p)) begin
        best_p    = prio_q[n];
        best_id_d = ID_W'(n + 1);
      end
    end
    irq_d = (best_id_d != '0);
  end

  always_comb begin
    prio_rd = '0;
    for (int n = 0; n < SOURCES; n++) begin
      if (prio_idx == 6'(n)) prio_rd = prio_q[n];
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (word == PLIC_PENDING[7:2]):   rd_val = 32'(pending);
      (word == PLIC_ENABLE[7:2]):    rd_val = 32'(enable_q);
      (word == PLIC_THRESHOLD[7:2]): rd_val = 32'(thresh_q);
      (word == PLIC_CLAIM[7:2]):     rd_val = 32'(best_id_q);
      is_prio:                       rd_val = 32'(prio_rd);
      default:                       rd_val = '0;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    for (int n = 0; n < SOURCES; n++) prio_d[n] = prio_q[n];
    if (wr) begin
      unique case (1'b1)
        (word == PLIC_ENABLE[7:2]):    enable_d = i_wdata[SOURCES-1:0];
        (word == PLIC_THRESHOLD[7:2]): thresh_d = i_wdata[PW-1:0];
        is_prio: begin
          for (int n = 0; n < SOURCES; n++) begin
            if (prio_idx == 6'(n)) prio_d[n] = i_wdata[PW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    unique case (state_q)
      BUS_IDLE: begin
        if (i_request) begin
          state_d = BUS_ACK;
          ready_d = 1'b1;
          rdata_d = i_rw ? 32'h0 : rd_val;
        end
      end
      BUS_ACK: begin
        if (!i_request) begin
          state_d = BUS_IDLE;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = BUS_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      enable_q  <= '0;
      thresh_q  <= '0;
      for (int n = 0; n < SOURCES; n++) prio_q[n] <= '0;
      best_id_q <= '0;
      irq_q     <= 1'b0;
      state_q   <= BUS_IDLE;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      thresh_q  <= thresh_d;
      for (int n = 0; n < SOURCES; n++) prio_q[n] <= prio_d[n];
      best_id_q <= best_id_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
    end
  end

  assign o_interrupt = irq_q;
  assign o_rdata     = rdata_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_cpu_plic.sv
// cpu_plic bench.
// Read results are queued at issue and compared on o_ready.
module tb_cpu_plic;
  import cpu_plic_pkg::*;

  localparam int SRC = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [SRC-1:0] irq;
  logic           o_interrupt;
  logic           req;
  logic           rw;
  logic [7:0]     addr;
  logic [31:0]    wdata;
  logic [31:0]    o_rdata;
  logic           o_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_plic #(.SOURCES(SRC), .PRIORITY_WIDTH(3)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_interrupt (irq),
    .o_interrupt (o_interrupt),
    .i_request   (req),
    .i_rw        (rw),
    .i_address   (addr),
    .i_wdata     (wdata),
    .o_rdata     (o_rdata),
    .o_ready     (o_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [7:0] a,
                     input logic [31:0] d, output logic [31:0] r,
                     output bit ok);
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    r = o_rdata;
    req = 1'b0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bit ok;
    bus(1'b1, a, d, r, ok);
    if (!ok) chk("wr_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_rd(input string tag, input logic [7:0] a,
                        input logic [31:0] e);
    logic [31:0] r;
    logic [31:0] ex;
    bit ok;
    exp_q.push_back(e);
    bus(1'b0, a, 32'h0, r, ok);
    ex = exp_q.pop_front();
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk(tag, r, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; irq = '0; req = 1'b0; rw = 1'b0;
    addr = '0; wdata = '0;
    idle(3);
    chk("rst_irq", 32'(o_interrupt), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    rst = 1'b0;

    // single source latency, claim, in-service mask, complete
    bus_wr(8'h04, 32'h04);
    bus_wr(8'h18, 32'd3);
    bus_wr(8'h08, 32'd0);
    @(negedge clk);
    irq[2] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      chk("lat_low", 32'(o_interrupt), 32'd0);
    end
    @(posedge clk); #1;
    chk("lat_high", 32'(o_interrupt), 32'd1);
    bus_rd("claim_3", 8'h0C, 32'd3);
    idle(2);
    chk("claimed_irq", 32'(o_interrupt), 32'd0);
    bus_rd("pend_after_claim", 8'h00, 32'h0);
    idle(4);
    chk("no_repend_irq", 32'(o_interrupt), 32'd0);
    bus_rd("no_repend", 8'h00, 32'h0);
    bus_wr(8'h0C, 32'd3);
    bus_rd("repend", 8'h00, 32'h04);
    bus_rd("claim_3b", 8'h0C, 32'd3);
    irq[2] = 1'b0;
    idle(3);
    bus_wr(8'h0C, 32'd3);

    // tie on priority: lowest ID wins
    bus_wr(8'h04, 32'h12);
    bus_wr(8'h14, 32'd5);
    bus_wr(8'h20, 32'd5);
    irq[1] = 1'b1; irq[4] = 1'b1;
    idle(5);
    bus_rd("tie_claim", 8'h0C, 32'd2);
    irq[1] = 1'b0;
    bus_wr(8'h0C, 32'd2);
    idle(4);
    bus_rd("tie_next", 8'h0C, 32'd5);
    irq[4] = 1'b0;
    idle(3);
    bus_wr(8'h0C, 32'd5);

    // threshold gating
    bus_wr(8'h04, 32'h08);
    bus_wr(8'h1C, 32'd2);
    bus_wr(8'h08, 32'd2);
    irq[3] = 1'b1;
    idle(6);
    chk("thr_block", 32'(o_interrupt), 32'd0);
    bus_wr(8'h08, 32'd1);
    @(posedge clk); #1;
    chk("thr_open", 32'(o_interrupt), 32'd1);
    bus_rd("thr_claim", 8'h0C, 32'd4);
    irq[3] = 1'b0;
    idle(3);
    bus_wr(8'h0C, 32'd4);
    bus_wr(8'h08, 32'd0);

    // empty claim, register readback, bogus complete
    idle(2);
    bus_rd("empty_claim", 8'h0C, 32'd0);
    bus_rd("empty_pend", 8'h00, 32'h0);
    bus_wr(8'h04, 32'hFFFF_FF40);
    bus_wr(8'h28, 32'd1);
    bus_wr(8'h30, 32'd7);
    bus_rd("unmapped_prio", 8'h30, 32'h0);
    bus_rd("enable_rb", 8'h04, 32'h40);
    bus_rd("prio6_rb", 8'h28, 32'h1);
    bus_rd("thresh_rb", 8'h08, 32'h0);
    irq[6] = 1'b1;
    idle(5);
    bus_wr(8'h0C, 32'd7);
    bus_rd("bogus_complete", 8'h00, 32'h40);
    chk("bogus_irq", 32'(o_interrupt), 32'd1);
    bus_rd("claim_7", 8'h0C, 32'd7);
    bus_wr(8'h0C, 32'd7);
    idle(5);
    chk("src6_irq", 32'(o_interrupt), 32'd1);

    // reset in the middle of an access
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 8'h04;
    @(posedge clk); #1;
    chk("mid_ready", 32'(o_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_ready", 32'(o_ready), 32'd0);
    chk("rst_drop_irq", 32'(o_interrupt), 32'd0);
    @(negedge clk);
    req = 1'b0; irq = '0;
    @(negedge clk);
    rst = 1'b0;
    bus_rd("enable_after_rst", 8'h04, 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
